// File: rtl/div_unit_rv32m.sv
// Multi-cycle radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Divide-by-zero and signed overflow skip the iteration loop and resolve in FIN.
module div_unit_rv32m #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [1:0]      funct,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int CW = $clog2(XLEN + 1);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIN, S_DONE} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] rem, quo, dvsr;
    logic            rem_op, neg_q, neg_r;

    logic            accept, is_signed, a_neg, b_neg, div0, ovf, special;
    logic [XLEN:0]   rem_sh, trial;
    logic [XLEN-1:0] q_fix, r_fix;

    assign accept    = start && (state == S_IDLE || state == S_DONE);
    assign is_signed = ~funct[0];
    assign a_neg     = is_signed & dividend[XLEN-1];
    assign b_neg     = is_signed & divisor[XLEN-1];
    assign div0      = (divisor == '0);
    assign ovf       = is_signed && (dividend == MIN_NEG) && (divisor == '1);
    assign special   = div0 | ovf;

    // The partial remainder shifted left with the next dividend bit pulled in
    assign rem_sh = {rem, quo[XLEN-1]};
    assign trial  = rem_sh - {1'b0, dvsr};
    assign q_fix  = neg_q ? (~quo + 1'b1) : quo;
    assign r_fix  = neg_r ? (~rem + 1'b1) : rem;

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: if (start) state_nxt = special ? S_FIN : S_CALC;
            S_CALC: begin
                busy = 1'b1;
                if (cnt == CW'(1)) state_nxt = S_FIN;
            end
            S_FIN: begin
                busy      = 1'b1;
                state_nxt = S_DONE;
            end
            S_DONE: begin
                done = 1'b1;
                if (start) state_nxt = special ? S_FIN : S_CALC;
                else       state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= '0;
            rem    <= '0;
            quo    <= '0;
            dvsr   <= '0;
            rem_op <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            result <= '0;
        end else if (accept) begin
            rem_op <= funct[1];
            cnt    <= CW'(XLEN);
            dvsr   <= b_neg ? (~divisor + 1'b1) : divisor;
            // Special cases preload the final quotient/remainder with no sign fix-up
            if (div0) begin
                quo   <= '1;
                rem   <= dividend;
                neg_q <= 1'b0;
                neg_r <= 1'b0;
            end else if (ovf) begin
                quo   <= MIN_NEG;
                rem   <= '0;
                neg_q <= 1'b0;
                neg_r <= 1'b0;
            end else begin
                quo   <= a_neg ? (~dividend + 1'b1) : dividend;
                rem   <= '0;
                neg_q <= a_neg ^ b_neg;
                neg_r <= a_neg;
            end
        end else if (state == S_CALC) begin
            cnt <= cnt - 1'b1;
            if (!trial[XLEN]) begin
                rem <= trial[XLEN-1:0];
                quo <= {quo[XLEN-2:0], 1'b1};
            end else begin
                rem <= rem_sh[XLEN-1:0];
                quo <= {quo[XLEN-2:0], 1'b0};
            end
        end else if (state == S_FIN) begin
            result <= rem_op ? r_fix : q_fix;
        end
    end
endmodule

// File: tb/tb_div_unit_rv32m.sv
// Directed-vector bench for div_unit_rv32m: results, latency, busy/done behaviour, reset abort.
module tb_div_unit_rv32m;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  funct = 2'b00;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic        busy, done;
    logic [31:0] result;

    int tests = 0;
    int fails = 0;

    localparam logic [1:0] F_DIV = 2'b00, F_DIVU = 2'b01, F_REM = 2'b10, F_REMU = 2'b11;

    div_unit_rv32m #(.XLEN(32)) dut (
        .clk(clk), .reset(reset), .start(start), .funct(funct),
        .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    // Present an op, take one edge with start high, then drop start.
    task automatic launch(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
        funct = f; dividend = a; divisor = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Wait for done; edges counts from the accept edge inclusive, bcyc counts busy samples.
    task automatic wait_done(input int e0, output logic [31:0] res, output int edges, output int bcyc);
        edges = e0; bcyc = 0; res = 'x;
        while (edges < 120) begin
            if (done) begin
                res = result;
                break;
            end
            if (busy) bcyc++;
            @(posedge clk); #1;
            edges++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
            fails++;
            $display("FAIL reset_state: busy=%b done=%b result=%h, need 0 0 00000000", busy, done, result);
        end
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL idle_quiet: busy=%b done=%b, need 0 0", busy, done);
        end
    endtask

    task automatic test_arith();
        logic [1:0]  f[9]   = '{F_DIV, F_REM, F_REM, F_DIVU, F_REMU, F_DIV, F_DIVU, F_REM, F_REMU};
        logic [31:0] a[9]   = '{32'd20, 32'd20, -32'sd20, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                32'd100, 32'h80000000, -32'sd7, 32'd5};
        logic [31:0] b[9]   = '{-32'sd3, -32'sd3, 32'd3, 32'd2, 32'd16,
                                32'd7, 32'd3, -32'sd2, 32'd9};
        logic [31:0] exp[9] = '{32'hFFFFFFFA, 32'h00000002, 32'hFFFFFFFE, 32'h7FFFFFFF,
                                32'h0000000F, 32'd14, 32'h2AAAAAAA, 32'hFFFFFFFF, 32'd5};
        logic [31:0] res;
        int edges, bcyc;
        for (int i = 0; i < 9; i++) begin
            launch(f[i], a[i], b[i]);
            wait_done(1, res, edges, bcyc);
            tests++;
            if (res !== exp[i]) begin
                fails++;
                $display("FAIL arith_%0d_result: got %h need %h", i, res, exp[i]);
            end
            tests++;
            if (edges != 34 || bcyc != 33) begin
                fails++;
                $display("FAIL arith_%0d_latency: edges=%0d busy=%0d need 34 33", i, edges, bcyc);
            end
            @(posedge clk); #1;
            tests++;
            if (done !== 1'b0 || result !== exp[i]) begin
                fails++;
                $display("FAIL arith_%0d_pulse: done=%b result=%h need 0 %h", i, done, result, exp[i]);
            end
        end
    endtask

    task automatic test_special();
        logic [1:0]  f[7]   = '{F_DIVU, F_REMU, F_DIV, F_REM, F_DIV, F_REM, F_DIVU};
        logic [31:0] a[7]   = '{32'd7, 32'd7, -32'sd5, -32'sd5, 32'h80000000, 32'h80000000, 32'h80000000};
        logic [31:0] b[7]   = '{32'd0, 32'd0, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0};
        logic [31:0] exp[7] = '{32'hFFFFFFFF, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFFB,
                                32'h80000000, 32'h0, 32'hFFFFFFFF};
        logic [31:0] res;
        int edges, bcyc;
        for (int i = 0; i < 7; i++) begin
            launch(f[i], a[i], b[i]);
            wait_done(1, res, edges, bcyc);
            tests++;
            if (res !== exp[i]) begin
                fails++;
                $display("FAIL special_%0d_result: got %h need %h", i, res, exp[i]);
            end
            tests++;
            if (edges != 2 || bcyc != 1) begin
                fails++;
                $display("FAIL special_%0d_latency: edges=%0d busy=%0d need 2 1", i, edges, bcyc);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] res;
        int edges, bcyc;
        launch(F_DIV, 32'd100, 32'd7);
        repeat (4) begin
            @(posedge clk); #1;
        end
        funct = F_DIVU; dividend = 32'd50; divisor = 32'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(6, res, edges, bcyc);
        tests++;
        if (res !== 32'd14 || edges != 34) begin
            fails++;
            $display("FAIL ignore_start: got %h edges=%0d need 0000000e 34", res, edges);
        end
        // done is high now; start in this cycle must be taken with no idle gap
        launch(F_REM, 32'd100, 32'd7);
        tests++;
        if (busy !== 1'b1 || done !== 1'b0 || result !== 32'd14) begin
            fails++;
            $display("FAIL b2b_accept: busy=%b done=%b result=%h need 1 0 0000000e", busy, done, result);
        end
        wait_done(1, res, edges, bcyc);
        tests++;
        if (res !== 32'd2 || edges != 34) begin
            fails++;
            $display("FAIL b2b_result: got %h edges=%0d need 00000002 34", res, edges);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_abort();
        logic [31:0] res;
        int edges, bcyc;
        launch(F_DIVU, 32'd1000, 32'd7);
        repeat (10) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        tests++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
            fails++;
            $display("FAIL abort_state: busy=%b done=%b result=%h need 0 0 00000000", busy, done, result);
        end
        reset = 1'b0;
        launch(F_DIVU, 32'd9, 32'd3);
        wait_done(1, res, edges, bcyc);
        tests++;
        if (res !== 32'd3 || edges != 34) begin
            fails++;
            $display("FAIL after_abort: got %h edges=%0d need 00000003 34", res, edges);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_arith();
        test_special();
        test_back_to_back();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
